// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage controller.
package mem_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMTOREG = 1'b0;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus; master = MEM stage controller, slave = memory.
interface mem_stage_ctrl_if #(parameter int N = 32);
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/Register_Pipe.sv
// Enabled pipeline register with synchronous active-high reset.
module Register_Pipe #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (reset)     q_o <= '0;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB register: bubble zeroes the control bits only, data fields hold.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int N          = DATA_W,
  parameter int REG_ADDR_W = REG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic                  rd_load_i,
  input  logic                  memtoreg_i,
  input  logic                  regwrite_i,
  input  logic [N-1:0]          read_data_i,
  input  logic [N-1:0]          alu_result_i,
  input  logic [REG_ADDR_W-1:0] write_reg_i,
  output logic                  memtoreg_o,
  output logic                  regwrite_o,
  output logic [N-1:0]          read_data_o,
  output logic [N-1:0]          alu_result_o,
  output logic [REG_ADDR_W-1:0] write_reg_o
);
  logic       data_en;
  logic [1:0] ctrl_d, ctrl_q;

  assign data_en = load_i & ~bubble_i;
  assign ctrl_d  = bubble_i ? {BUBBLE_MEMTOREG, BUBBLE_REGWRITE} : {memtoreg_i, regwrite_i};
  assign {memtoreg_o, regwrite_o} = ctrl_q;

  Register_Pipe #(.W(2)) u_ctrl (
    .clk(clk), .reset(reset), .en_i(load_i | bubble_i), .d_i(ctrl_d), .q_o(ctrl_q));
  Register_Pipe #(.W(N)) u_rdata (
    .clk(clk), .reset(reset), .en_i(data_en & rd_load_i), .d_i(read_data_i), .q_o(read_data_o));
  Register_Pipe #(.W(N)) u_alu (
    .clk(clk), .reset(reset), .en_i(data_en), .d_i(alu_result_i), .q_o(alu_result_o));
  Register_Pipe #(.W(REG_ADDR_W)) u_wreg (
    .clk(clk), .reset(reset), .en_i(data_en), .d_i(write_reg_i), .q_o(write_reg_o));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolve, multi-cycle data-memory handshake, MEM/WB load.
// Optional access watchdog enabled by MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int N              = DATA_W,
  parameter int REG_ADDR_W     = REG_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_beq,
  input  logic                  ex_bne,
  input  logic                  ex_memread,
  input  logic                  ex_memwrite,
  input  logic                  ex_memtoreg,
  input  logic                  ex_regwrite,
  input  logic [N-1:0]          ex_alu_result,
  input  logic                  ex_alu_zero,
  input  logic [N-1:0]          ex_branch_target,
  input  logic [N-1:0]          ex_read_data2,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  mem_stage_ctrl_if.master      mem,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [N-1:0]          branch_target,
  output logic                  flush,
  output logic                  wb_memtoreg,
  output logic                  wb_regwrite,
  output logic [N-1:0]          wb_read_data,
  output logic [N-1:0]          wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic                  mem_err
);
  state_e       state_q, state_d;
  logic         op_present, expire, req_w, stall_w, bubble;
  logic [N-1:0] addr_q, wdata_q;
  logic         we_q;

  assign op_present = ex_memread | ex_memwrite;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Expires on the TIMEOUT_CYCLES-th un-acked ACCESS cycle; an ack that cycle wins.
  assign expire  = (state_q == ST_ACCESS) & ~mem.mem_ack &
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= expire;
      if (state_q == ST_IDLE)  cnt_q <= '0;
      else if (!mem.mem_ack)   cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (op_present) state_d = ST_ACCESS;
      ST_ACCESS: if (mem.mem_ack || expire) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_w   = 1'b0;
    stall_w = 1'b0;
    unique case (state_q)
      ST_IDLE:   stall_w = op_present;
      ST_ACCESS: begin
        req_w   = 1'b1;
        stall_w = ~mem.mem_ack & ~expire;
      end
      default: ;
    endcase
  end

  // Address/data/direction are frozen here so the bus stays stable until ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (state_q == ST_IDLE && op_present) begin
      addr_q  <= ex_alu_result;
      wdata_q <= ex_read_data2;
      we_q    <= ex_memwrite;
    end
  end

  assign mem.mem_req   = req_w;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign stall         = stall_w;
  assign branch_taken  = ~stall_w & ((ex_beq & ex_alu_zero) | (ex_bne & ~ex_alu_zero));
  assign flush         = branch_taken;
  assign branch_target = ex_branch_target;

  // EX/MEM is frozen while stalled, so at ack the ex_* fields still describe the access.
  assign bubble = stall_w | expire;

  mem_wb_reg #(.N(N), .REG_ADDR_W(REG_ADDR_W)) u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .load_i       (~bubble),
    .bubble_i     (bubble),
    .rd_load_i    ((state_q == ST_ACCESS) & ~we_q),
    .memtoreg_i   (ex_memtoreg),
    .regwrite_i   (ex_regwrite),
    .read_data_i  (mem.mem_rdata),
    .alu_result_i (ex_alu_result),
    .write_reg_i  (ex_write_reg),
    .memtoreg_o   (wb_memtoreg),
    .regwrite_o   (wb_regwrite),
    .read_data_o  (wb_read_data),
    .alu_result_o (wb_alu_result),
    .write_reg_o  (wb_write_reg)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed plus randomized transaction-level checks of mem_stage_ctrl.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_beq, ex_bne, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_alu_zero;
  logic [31:0] ex_alu_result, ex_branch_target, ex_read_data2;
  logic [4:0]  ex_write_reg;
  logic        stall, branch_taken, flush, wb_memtoreg, wb_regwrite, mem_err;
  logic [31:0] branch_target, wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model of the MEM/WB register contents
  logic        m_rw, m_mt;
  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_wr;

  mem_stage_ctrl_if #(.N(32)) mif ();

  mem_stage_ctrl #(.N(32), .REG_ADDR_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_alu_result(ex_alu_result),
    .ex_alu_zero(ex_alu_zero), .ex_branch_target(ex_branch_target),
    .ex_read_data2(ex_read_data2), .ex_write_reg(ex_write_reg),
    .mem(mif.master),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, ".wb_regwrite"},   32'(wb_regwrite),   32'(m_rw));
    chk({tag, ".wb_memtoreg"},   32'(wb_memtoreg),   32'(m_mt));
    chk({tag, ".wb_read_data"},  wb_read_data,       m_rd);
    chk({tag, ".wb_alu_result"}, wb_alu_result,      m_alu);
    chk({tag, ".wb_write_reg"},  32'(wb_write_reg),  32'(m_wr));
  endtask

  task automatic clr_ex();
    {ex_beq, ex_bne, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_alu_zero} = '0;
    ex_alu_result = '0; ex_branch_target = '0; ex_read_data2 = '0; ex_write_reg = '0;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (write wins). Ack on ACCESS cycle dly+1.
  task automatic txn(input string tag, input int kind, input int dly, input logic rw, input logic mt,
                     input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd,
                     input logic [31:0] rd, input logic beq, input logic bne, input logic zero,
                     input logic [31:0] bt);
    bit op, exp_stall, exp_req, exp_bt;
    int ncyc;
    ex_memread = (kind == 1 || kind == 3); ex_memwrite = (kind >= 2);
    ex_regwrite = rw; ex_memtoreg = mt; ex_write_reg = wr; ex_alu_result = alu;
    ex_read_data2 = wd; ex_beq = beq; ex_bne = bne; ex_alu_zero = zero; ex_branch_target = bt;
    op   = (kind != 0);
    ncyc = op ? dly + 2 : 1;
    for (int c = 0; c < ncyc; c++) begin
      mif.mem_ack   = op && (c == dly + 1);
      mif.mem_rdata = (op && c == dly + 1) ? rd : $urandom;
      exp_stall = op && (c <= dly);
      exp_req   = op && (c >= 1);
      exp_bt    = !exp_stall && ((beq && zero) || (bne && !zero));
      @(negedge clk);
      chk({tag, ".stall"},   32'(stall),   32'(exp_stall));
      chk({tag, ".mem_req"}, 32'(mif.mem_req), 32'(exp_req));
      if (exp_req) begin
        chk({tag, ".mem_addr"}, mif.mem_addr, alu);
        chk({tag, ".mem_we"},   32'(mif.mem_we), 32'(kind >= 2));
        if (kind >= 2) chk({tag, ".mem_wdata"}, mif.mem_wdata, wd);
      end
      chk({tag, ".branch_taken"},  32'(branch_taken), 32'(exp_bt));
      chk({tag, ".flush"},         32'(flush),        32'(exp_bt));
      chk({tag, ".branch_target"}, branch_target,     bt);
      chk({tag, ".mem_err"},       32'(mem_err),      32'd0);
      @(posedge clk); #1;
      if (c < ncyc - 1) begin
        m_rw = 1'b0; m_mt = 1'b0;
        chk({tag, ".bubble_regwrite"}, 32'(wb_regwrite), 32'd0);
        chk({tag, ".bubble_memtoreg"}, 32'(wb_memtoreg), 32'd0);
      end
    end
    m_rw = rw; m_mt = mt; m_alu = alu; m_wr = wr;
    if (kind == 1) m_rd = rd;
    chk_wb(tag);
    mif.mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_ex();
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    m_rw = 0; m_mt = 0; m_rd = 0; m_alu = 0; m_wr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_wb("reset");
    chk("reset.mem_req", 32'(mif.mem_req), 32'd0);
    chk("reset.stall",   32'(stall),       32'd0);
    chk("reset.mem_err", 32'(mem_err),     32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    txn("alu",   0, 0, 1, 0, 5'd9, 32'h0000_00A5, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    txn("load",  1, 2, 1, 1, 5'd7, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    txn("store", 2, 1, 0, 0, 5'd3, 32'h0000_0080, 32'h0000_1234, 32'h5555_5555, 0, 0, 0, 32'h0);
    txn("beq",   0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 0, 1, 32'h0000_0100);
    txn("bne",   0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0000_0100);
    txn("both0", 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 1, 0, 32'h0000_0100);
    txn("both1", 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 1, 1, 32'h0000_0100);
    txn("rdwr",  3, 0, 1, 0, 5'd4, 32'h0000_00C0, 32'hCAFE_F00D, 32'h1111_2222, 0, 0, 0, 32'h0);
    txn("ldbr",  1, 0, 1, 1, 5'd2, 32'h0000_0044, 32'h0, 32'h7777_0001, 1, 0, 1, 32'h0000_0200);

    // Reset in the 2nd ACCESS cycle; the ack one cycle later must be ignored.
    ex_memread = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_alu_result = 32'h60; ex_write_reg = 5'd12;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.mem_req", 32'(mif.mem_req), 32'd0);
    m_rw = 0; m_mt = 0; m_rd = 0; m_alu = 0; m_wr = 0;
    chk_wb("rst_mid");
    reset = 1'b0;
    clr_ex();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rst_ack.mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_ack.stall",   32'(stall),       32'd0);
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    chk_wb("rst_ack");
    @(negedge clk);
    chk("rst_ack.idle_req", 32'(mif.mem_req), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      txn("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack: four ACCESS cycles, then error pulse and release.
    ex_memread = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_alu_result = 32'h90; ex_write_reg = 5'd5;
    mif.mem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("to.stall",   32'(stall),       32'(c < 4));
      chk("to.mem_req", 32'(mif.mem_req), 32'(c >= 1));
      chk("to.mem_err", 32'(mem_err),     32'd0);
      @(posedge clk); #1;
    end
    clr_ex();
    m_rw = 0; m_mt = 0;
    chk_wb("to");
    @(negedge clk);
    chk("to.err_pulse", 32'(mem_err),     32'd1);
    chk("to.idle_req",  32'(mif.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to.err_clear", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
